cim_bitplane_accumulator: RTL and testbench

- Downstream consumer of the SRAM compute-in-memory macro's 64-bit DOut bus.
- The macro is driven bit-serially: one input bit-plane on In_B per pass, MSB plane first.
- Each pass yields 64 column product bits. This block popcounts each plane, shift-accumulates NUM_PLANES planes into one multi-bit dot-product result, and hands it off with a valid/ready handshake.

---
 rtl/cim_bitplane_accumulator.sv | 153 +++++++++++++++
 tb/tb_cim_bitplane_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_bitplane_accumulator.sv
// cim_bitplane_accumulator
// Consumes the 64-bit DOut bus of a bit-serially driven SRAM compute-in-memory
// macro. Each valid plane is popcounted and shift-accumulated, MSB plane first,
// into an ACC_W-bit dot-product result. The result is offered downstream on a
// valid/ready handshake.
//
// Build option: define CIM_ACC_SIGNED_EN to treat the input vector as two's
// complement. The MSB plane is then subtracted and Acc_Out is signed. When the
// macro is left undefined, every plane adds and Acc_Out is unsigned.
//
// Handshake (Acc_Valid / Acc_Ready): a transfer happens on any rising Clk edge
// where both are high. Once Acc_Valid rises, it and Acc_Out stay unchanged
// until that transfer. Acc_Valid never depends combinationally on Acc_Ready.
//
// dbg_state exposes the FSM state register: 0 = IDLE, 1 = ACCUM, 2 = DONE.

module cim_bitplane_accumulator #(
  parameter  int NUM_PLANES = 8,
  localparam int ACC_W      = NUM_PLANES + 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             DValid,
  input  logic [63:0]      DOut,
  output logic [3:0]       Plane_Idx,
  output logic             Busy,
  output logic [ACC_W-1:0] Acc_Out,
  output logic             Acc_Valid,
  input  logic             Acc_Ready,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_PLANES - 1);

  state_t           state_q,     state_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [3:0]       plane_idx_q, plane_idx_d;
  logic [ACC_W-1:0] acc_out_q,   acc_out_d;
  logic             acc_valid_q, acc_valid_d;

  logic [6:0]       pc;
  logic [ACC_W-1:0] pc_ext;
  logic [ACC_W-1:0] acc_shifted;
  logic             first_plane;
  logic [ACC_W-1:0] plane_sum;

  // Count the ones in the current plane (0..64). This value feeds only acc.
  always_comb begin
    pc = 7'd0;
    for (int i = 0; i < 64; i++) begin
      pc = pc + {6'd0, DOut[i]};
    end
  end

  // Value acc takes when the current plane is consumed.
  always_comb begin
    pc_ext      = ACC_W'(pc);
    acc_shifted = {acc_q[ACC_W-2:0], 1'b0};
    first_plane = (plane_idx_q == LAST_IDX);
`ifdef CIM_ACC_SIGNED_EN
    // The MSB plane carries negative weight in two's complement. acc is zero
    // at that point, so the first plane becomes a plain negation of pc.
    if (first_plane) begin
      plane_sum = '0 - pc_ext;
    end else begin
      plane_sum = acc_shifted + pc_ext;
    end
`else
    // In unsigned mode acc is zero on the first plane, so the shift is
    // harmless there and every plane uses the same update rule.
    plane_sum = acc_shifted + pc_ext;
`endif
  end

  // Next-state and datapath decisions for the IDLE -> ACCUM -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    plane_idx_d = plane_idx_q;
    acc_out_d   = acc_out_q;
    acc_valid_d = acc_valid_q;
    case (state_q)
      S_IDLE: begin
        // DValid is ignored in IDLE. Only Start moves the FSM.
        if (Start) begin
          acc_d       = '0;
          plane_idx_d = LAST_IDX;
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // No timeout: the FSM waits as long as needed for each plane.
        if (DValid) begin
          acc_d = plane_sum;
          if (plane_idx_q == 4'd0) begin
            acc_out_d   = plane_sum;
            acc_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            plane_idx_d = plane_idx_q - 4'd1;
          end
        end
      end
      S_DONE: begin
        // Start and DValid are ignored here, including in the handoff cycle.
        if (acc_valid_q && Acc_Ready) begin
          acc_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_d       = '0;
        plane_idx_d = 4'd0;
        acc_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset drops any partial
  // result.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      plane_idx_q <= 4'd0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      plane_idx_q <= plane_idx_d;
      acc_out_q   <= acc_out_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  // plane_idx_q reaches 0 on the last plane and is loaded only on Start, so it
  // already reads 0 in IDLE and DONE.
  assign Plane_Idx = plane_idx_q;
  assign Busy      = (state_q != S_IDLE);
  assign Acc_Out   = acc_out_q;
  assign Acc_Valid = acc_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cim_bitplane_accumulator.sv
// Testbench for cim_bitplane_accumulator (NUM_PLANES = 8). It applies directed
// table vectors and hand-written corner sequences, then random transactions
// that are checked against a weighted-sum reference model.
// Define CIM_ACC_SIGNED_EN for both the bench and the RTL to cover the signed
// build.

module tb_cim_bitplane_accumulator;

  localparam int NP = 8;
  localparam int AW = NP + 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic          DValid;
  logic [63:0]   DOut;
  logic [3:0]    Plane_Idx;
  logic          Busy;
  logic [AW-1:0] Acc_Out;
  logic          Acc_Valid;
  logic          Acc_Ready;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  cim_bitplane_accumulator #(.NUM_PLANES(NP)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .DValid(DValid), .DOut(DOut),
    .Plane_Idx(Plane_Idx), .Busy(Busy), .Acc_Out(Acc_Out),
    .Acc_Valid(Acc_Valid), .Acc_Ready(Acc_Ready), .dbg_state(dbg_state)
  );

  // Clock block
  always #5 Clk = ~Clk;

  // Each vector gives the popcount of the first plane, of the middle planes
  // and of the last plane, the idle gap before each plane, and the expected
  // Acc_Out bit pattern.
  typedef struct {
    string         name;
    int            pc_first;
    int            pc_mid;
    int            pc_last;
    int            gap;
    logic [AW-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  // Scoreboard: results expected from the random transactions.
  logic [AW-1:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Step one full cycle. The bench samples outputs and drives inputs at the
  // falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Build a random 64-bit plane with exactly pc ones.
  function automatic logic [63:0] make_dout(input int pc);
    logic [63:0] d;
    int n;
    int k;
    d = '0;
    n = 0;
    while (n < pc) begin
      k = $urandom_range(63, 0);
      if (!d[k]) begin
        d[k] = 1'b1;
        n++;
      end
    end
    return d;
  endfunction

  // Reference model: the dot product as a weighted sum of plane popcounts.
  // In signed mode the MSB plane carries weight -2^(NP-1).
  function automatic logic [AW-1:0] model(input int pcs[NP]);
    longint sum;
    longint w;
    sum = 0;
    for (int i = 0; i < NP; i++) begin
      w = longint'(1) << (NP - 1 - i);
`ifdef CIM_ACC_SIGNED_EN
      if (i == 0) sum = sum - pcs[i] * w;
      else        sum = sum + pcs[i] * w;
`else
      sum = sum + pcs[i] * w;
`endif
    end
    return sum[AW-1:0];
  endfunction

  // Driver task: pulse Start.
  task automatic start_pulse(input string tag);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check({tag, " busy after start"}, Busy, 1);
    check({tag, " idx after start"}, Plane_Idx, NP - 1);
  endtask

  // Driver task: send all planes with `gap` idle cycles before each one, then
  // check the result as soon as it should appear.
  task automatic send_planes(input int pcs[NP], input int gap,
                             input logic [AW-1:0] exp, input string tag);
    for (int i = 0; i < NP; i++) begin
      for (int g = 0; g < gap; g++) begin
        DValid = 1'b0;
        tick();
        check({tag, " idx held in gap"}, Plane_Idx, NP - 1 - i);
      end
      check({tag, " busy mid-accum"}, Busy, 1);
      DOut   = make_dout(pcs[i]);
      DValid = 1'b1;
      tick();
      DValid = 1'b0;
      if (i < NP - 1) check({tag, " idx step"}, Plane_Idx, NP - 2 - i);
    end
    check({tag, " valid 1 cycle after last plane"}, Acc_Valid, 1);
    check({tag, " acc_out"}, Acc_Out, exp);
    check({tag, " idx 0 in done"}, Plane_Idx, 0);
    check({tag, " busy in done"}, Busy, 1);
  endtask

  // Driver task: hold Acc_Ready low for `delay` cycles, then complete the
  // handoff.
  task automatic accept(input int delay, input logic [AW-1:0] exp, input string tag);
    Acc_Ready = 1'b0;
    for (int d = 0; d < delay; d++) begin
      tick();
      check({tag, " valid held"}, Acc_Valid, 1);
      check({tag, " out stable"}, Acc_Out, exp);
    end
    Acc_Ready = 1'b1;
    tick();
    Acc_Ready = 1'b0;
    check({tag, " valid drops"}, Acc_Valid, 0);
    check({tag, " idle after handoff"}, Busy, 0);
  endtask

  initial begin
    int            pcs[NP];
    logic [AW-1:0] e;
    logic [AW-1:0] got;

    Rst = 1'b1; Start = 1'b0; DValid = 1'b0; DOut = '0; Acc_Ready = 1'b0;

    // Directed vectors. Signed values are stored as their two's-complement
    // bit patterns.
`ifdef CIM_ACC_SIGNED_EN
    tbl[0] = '{"full_ones",  64, 64, 64, 0, -16'sd64};
    tbl[1] = '{"gapped",      1,  0,  1, 3, -16'sd127};
    tbl[2] = '{"pc2",         2,  2,  2, 0, -16'sd2};
    tbl[3] = '{"msb_only",   64,  0,  0, 0, -16'sd8192};
    tbl[4] = '{"lower_ones",  0, 64, 64, 1, 16'd8128};
    tbl[5] = '{"zeros",       0,  0,  0, 0, 16'd0};
`else
    tbl[0] = '{"full_ones",  64, 64, 64, 0, 16'd16320};
    tbl[1] = '{"gapped",      1,  0,  1, 3, 16'd129};
    tbl[2] = '{"pc2",         2,  2,  2, 0, 16'd510};
    tbl[3] = '{"msb_only",   64,  0,  0, 0, 16'd8192};
    tbl[4] = '{"lower_ones",  0, 64, 64, 1, 16'd8128};
    tbl[5] = '{"zeros",       0,  0,  0, 0, 16'd0};
`endif

    // Reset, then idle
    #500;
    check("reset acc_out", Acc_Out, 0);
    check("reset acc_valid", Acc_Valid, 0);
    check("reset busy", Busy, 0);
    check("reset plane_idx", Plane_Idx, 0);
    check("reset dbg_state", dbg_state, 0);
    Rst = 1'b0;
    tick();
    DOut = '1;
    for (int i = 0; i < 3; i++) begin
      DValid = 1'b1;
      tick();
    end
    DValid = 1'b0;
    check("idle dvalid busy", Busy, 0);
    check("idle dvalid acc_valid", Acc_Valid, 0);
    check("idle dvalid acc_out", Acc_Out, 0);
    check("idle dvalid plane_idx", Plane_Idx, 0);

    // Table-driven vectors
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NP; i++) begin
        pcs[i] = (i == 0) ? tbl[t].pc_first :
                 (i == NP - 1) ? tbl[t].pc_last : tbl[t].pc_mid;
      end
      start_pulse(tbl[t].name);
      send_planes(pcs, tbl[t].gap, tbl[t].exp, tbl[t].name);
      accept(0, tbl[t].exp, tbl[t].name);
    end

    // Backpressure: Start must be ignored while DONE waits on Acc_Ready.
    for (int i = 0; i < NP; i++) pcs[i] = $urandom_range(64, 0);
    e = model(pcs);
    start_pulse("bp");
    send_planes(pcs, 0, e, "bp");
    Acc_Ready = 1'b0;
    for (int d = 0; d < 10; d++) begin
      Start = (d % 3 == 0);
      tick();
      check("bp valid held", Acc_Valid, 1);
      check("bp out stable", Acc_Out, e);
      check("bp idx stays 0", Plane_Idx, 0);
    end
    // Start arriving in the handoff cycle is also ignored.
    Start = 1'b1;
    Acc_Ready = 1'b1;
    tick();
    Start = 1'b0;
    Acc_Ready = 1'b0;
    check("bp valid drops", Acc_Valid, 0);
    check("bp start in handoff ignored", Busy, 0);
    for (int i = 0; i < NP; i++) pcs[i] = 64 - i;
    e = model(pcs);
    start_pulse("bp_next");
    send_planes(pcs, 0, e, "bp_next");
    accept(1, e, "bp_next");

    // Reset in the middle of an accumulation
    for (int i = 0; i < NP; i++) pcs[i] = 50;
    start_pulse("rst_mid");
    for (int i = 0; i < 4; i++) begin
      DOut = make_dout(pcs[i]);
      DValid = 1'b1;
      tick();
    end
    DValid = 1'b0;
    Rst = 1'b1;
    #1;
    check("rst_mid busy", Busy, 0);
    check("rst_mid plane_idx", Plane_Idx, 0);
    check("rst_mid acc_valid", Acc_Valid, 0);
    check("rst_mid acc_out", Acc_Out, 0);
    check("rst_mid dbg_state", dbg_state, 0);
    tick();
    Rst = 1'b0;
    tick();
    for (int i = 0; i < NP; i++) pcs[i] = 2;
    e = model(pcs);
    start_pulse("rst_fresh");
    send_planes(pcs, 0, e, "rst_fresh");
    accept(0, e, "rst_fresh");

    // Random transactions scored through the expected queue
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NP; i++) begin
        case ($urandom_range(3, 0))
          0:       pcs[i] = 0;
          1:       pcs[i] = 64;
          default: pcs[i] = $urandom_range(64, 0);
        endcase
      end
      exp_q.push_back(model(pcs));
      start_pulse("rand");
      send_planes(pcs, $urandom_range(2, 0), exp_q[0], "rand");
      got = Acc_Out;
      accept($urandom_range(3, 0), exp_q[0], "rand");
      check("rand scoreboard", got, exp_q.pop_front());
      for (int g = $urandom_range(2, 0); g > 0; g--) tick();
    end
    check("scoreboard drained", exp_q.size(), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
